// File: rtl/au_arbiter_if.sv
// Requester-side and au-side signals of the au arbiter, bundled for port use.
// Latency: n/a (wiring only).  Backpressure: req is held until gnt; au_busy stalls au_start.
interface au_arbiter_if #(
    parameter int N = 4,
    parameter int W = 24
);
    logic [N-1:0]   req;
    logic [N*W-1:0] req_R;
    logic [N*W-1:0] req_S;
    logic [N*W-1:0] req_imm;
    logic [N*2-1:0] req_op;
    logic [N*2-1:0] req_ysel;
    logic [N-1:0]   gnt;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_data;
    logic           rsp_err;
    logic           busy;
    logic           au_start;
    logic [W-1:0]   au_R;
    logic [W-1:0]   au_S;
    logic [W-1:0]   au_Iimm;
    logic [1:0]     au_op_sel;
    logic [1:0]     au_mul_y_sel;
    logic [W-1:0]   au_result;
    logic           au_done;
    logic           au_busy;

    // Arbiter view
    modport slave (
        input  req, req_R, req_S, req_imm, req_op, req_ysel,
        input  au_result, au_done, au_busy,
        output gnt, rsp_valid, rsp_data, rsp_err, busy,
        output au_start, au_R, au_S, au_Iimm, au_op_sel, au_mul_y_sel
    );

    // Requesters plus arithmetic unit view
    modport master (
        output req, req_R, req_S, req_imm, req_op, req_ysel,
        output au_result, au_done, au_busy,
        input  gnt, rsp_valid, rsp_data, rsp_err, busy,
        input  au_start, au_R, au_S, au_Iimm, au_op_sel, au_mul_y_sel
    );
endinterface

// File: rtl/au_arbiter.sv
// Round-robin sharing of one arithmetic unit between N requesters, one op in flight.
// Latency: req to rsp_valid = 4 cycles + au latency (or TIMEOUT on a hung au).
// Backpressure: requests wait while busy; au_start is held off while au_busy is high.
module au_arbiter #(
    parameter int N       = 4,
    parameter int W       = 24,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    au_arbiter_if.slave bus
);
    localparam int IW = $clog2(N);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] owner;
    logic [TW-1:0] timer;

    logic          pick_vld;
    logic [IW-1:0] pick_idx;
    logic [W-1:0]  sel_R;
    logic [W-1:0]  sel_S;
    logic [W-1:0]  sel_imm;
    logic [1:0]    sel_op;
    logic [1:0]    sel_ysel;

    // First set request at or above ptr, wrapping around to 0.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (!pick_vld && bus.req[(int'(ptr) + k) % N]) begin
                pick_vld = 1'b1;
                pick_idx = IW'((int'(ptr) + k) % N);
            end
        end
    end

    always_comb begin
        sel_R    = '0;
        sel_S    = '0;
        sel_imm  = '0;
        sel_op   = '0;
        sel_ysel = '0;
        for (int k = 0; k < N; k++) begin
            if (pick_idx == IW'(k)) begin
                sel_R    = bus.req_R[k*W +: W];
                sel_S    = bus.req_S[k*W +: W];
                sel_imm  = bus.req_imm[k*W +: W];
                sel_op   = bus.req_op[k*2 +: 2];
                sel_ysel = bus.req_ysel[k*2 +: 2];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            ptr              <= '0;
            owner            <= '0;
            timer            <= '0;
            bus.gnt          <= '0;
            bus.rsp_valid    <= '0;
            bus.rsp_data     <= '0;
            bus.rsp_err      <= 1'b0;
            bus.busy         <= 1'b0;
            bus.au_start     <= 1'b0;
            bus.au_R         <= '0;
            bus.au_S         <= '0;
            bus.au_Iimm      <= '0;
            bus.au_op_sel    <= '0;
            bus.au_mul_y_sel <= '0;
        end else begin
            bus.gnt       <= '0;
            bus.rsp_valid <= '0;
            bus.au_start  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        owner            <= pick_idx;
                        bus.au_R         <= sel_R;
                        bus.au_S         <= sel_S;
                        bus.au_Iimm      <= sel_imm;
                        bus.au_op_sel    <= sel_op;
                        bus.au_mul_y_sel <= sel_ysel;
                        bus.gnt          <= N'(1) << pick_idx;
                        bus.busy         <= 1'b1;
                        state            <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!bus.au_busy) begin
                        bus.au_start <= 1'b1;
                        timer        <= '0;
                        state        <= WAIT;
                    end
                end
                WAIT: begin
                    timer <= timer + 1'b1;
                    // au_done is a level held from the previous op; ignore it while our start is still visible.
                    if (bus.au_done && !bus.au_start) begin
                        bus.rsp_data  <= bus.au_result;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_valid <= N'(1) << owner;
                        state         <= RESP;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        bus.rsp_data  <= '0;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_valid <= N'(1) << owner;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    ptr      <= (owner == IW'(N - 1)) ? '0 : owner + 1'b1;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_au_arbiter.sv
// Directed bench for au_arbiter: stimulus pushes expectations, a negedge monitor pops and compares.
// A behavioural au stub divides R by S in sign-magnitude S9.14 after a fixed latency.
module tb_au_arbiter;
    localparam int N      = 4;
    localparam int W      = 24;
    localparam int AU_LAT = 24;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    au_arbiter_if #(.N(N), .W(W)) bus ();

    au_arbiter #(.N(N), .W(W), .TIMEOUT(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        int          owner;
        logic [23:0] r;
        logic [23:0] s;
        logic [23:0] imm;
        logic [1:0]  op;
        logic [1:0]  ys;
        logic [23:0] data;
        logic        err;
    } exp_t;

    exp_t gq[$];
    exp_t aq[$];
    exp_t rq[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int start_cyc = 0;
    bit prev_start = 1'b0;
    bit hang = 1'b0;

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // au stub: done is a level, dropped when a new start is seen
    int          au_cnt = 0;
    bit          au_pend = 1'b0;
    logic [23:0] au_res = '0;
    initial begin
        bus.au_done   = 1'b0;
        bus.au_result = '0;
    end
    always @(posedge clk) begin
        if (bus.au_start) begin
            logic [36:0] q;
            q = {bus.au_R[22:0], 14'b0} / {14'b0, bus.au_S[22:0]};
            bus.au_done <= 1'b0;
            au_pend     <= !hang;
            au_cnt      <= AU_LAT;
            au_res      <= {bus.au_R[23] ^ bus.au_S[23], q[22:0]};
        end else if (au_pend) begin
            if (au_cnt == 1) begin
                bus.au_done   <= 1'b1;
                bus.au_result <= au_res;
                au_pend       <= 1'b0;
            end
            au_cnt <= au_cnt - 1;
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.gnt != '0) begin
                if (gq.size() == 0) fail_now($sformatf("gnt unexpected actual=%0h", bus.gnt));
                else begin
                    exp_t e;
                    e = gq.pop_front();
                    chk("gnt", 128'(bus.gnt), 128'(4'b1 << e.owner));
                end
            end
            if (bus.au_start) begin
                if (prev_start) fail_now("au_start longer than one cycle");
                else if (aq.size() == 0) fail_now("au_start unexpected");
                else begin
                    exp_t e;
                    e = aq.pop_front();
                    chk("au_operands",
                        128'({bus.au_R, bus.au_S, bus.au_Iimm, bus.au_op_sel, bus.au_mul_y_sel}),
                        128'({e.r, e.s, e.imm, e.op, e.ys}));
                end
                start_cyc = cyc;
            end
            prev_start = bus.au_start;
            if (bus.rsp_valid != '0) begin
                if (rq.size() == 0) fail_now($sformatf("rsp_valid unexpected actual=%0h", bus.rsp_valid));
                else begin
                    exp_t e;
                    e = rq.pop_front();
                    chk("rsp_valid", 128'(bus.rsp_valid), 128'(4'b1 << e.owner));
                    chk("rsp_data", 128'(bus.rsp_data), 128'(e.data));
                    chk("rsp_err", 128'(bus.rsp_err), 128'(e.err));
                    if (e.err) chk("timeout_latency", 128'(cyc - start_cyc), 128'(64));
                end
            end
        end else begin
            prev_start = 1'b0;
        end
    end

    task automatic set_ops(int i, logic [23:0] r, logic [23:0] s, logic [1:0] op);
        bus.req_R[i*W +: W]   = r;
        bus.req_S[i*W +: W]   = s;
        bus.req_imm[i*W +: W] = 24'h000100 * i;
        bus.req_op[i*2 +: 2]  = op;
        bus.req_ysel[i*2 +: 2] = 2'b10;
    endtask

    task automatic expect_txn(int i, logic [23:0] data, logic err, bit with_rsp);
        exp_t e;
        e.owner = i;
        e.r     = bus.req_R[i*W +: W];
        e.s     = bus.req_S[i*W +: W];
        e.imm   = bus.req_imm[i*W +: W];
        e.op    = bus.req_op[i*2 +: 2];
        e.ys    = bus.req_ysel[i*2 +: 2];
        e.data  = data;
        e.err   = err;
        gq.push_back(e);
        aq.push_back(e);
        if (with_rsp) rq.push_back(e);
    endtask

    task automatic wait_gnt(int i);
        for (int n = 0; n < 300; n++) begin
            @(posedge clk);
            #1;
            if (bus.gnt[i]) return;
        end
        fail_now($sformatf("timeout waiting for gnt[%0d]", i));
    endtask

    task automatic drain();
        for (int n = 0; n < 400; n++) begin
            @(posedge clk);
            #1;
            if (rq.size() == 0 && !bus.busy) return;
        end
        fail_now("timeout waiting for responses to drain");
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_gnt", 128'(bus.gnt), 128'(0));
        chk("rst_rsp_valid", 128'(bus.rsp_valid), 128'(0));
        chk("rst_rsp_data", 128'(bus.rsp_data), 128'(0));
        chk("rst_rsp_err", 128'(bus.rsp_err), 128'(0));
        chk("rst_busy", 128'(bus.busy), 128'(0));
        chk("rst_au_start", 128'(bus.au_start), 128'(0));
        chk("rst_au_operands",
            128'({bus.au_R, bus.au_S, bus.au_Iimm, bus.au_op_sel, bus.au_mul_y_sel}), 128'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req      = '0;
        bus.req_R    = '0;
        bus.req_S    = '0;
        bus.req_imm  = '0;
        bus.req_op   = '0;
        bus.req_ysel = '0;
        bus.au_busy  = 1'b0;
        #2;
        do_reset();

        // 1: single divide, 1.0 / 2.0
        set_ops(1, 24'h004000, 24'h008000, 2'b11);
        expect_txn(1, 24'h002000, 1'b0, 1'b1);
        bus.req[1] = 1'b1;
        wait_gnt(1);
        bus.req[1] = 1'b0;
        drain();

        // 2: all four held, rotation 0,1,2,3,0 from a fresh pointer
        do_reset();
        set_ops(0, 24'h004000, 24'h010000, 2'b11);
        set_ops(1, 24'h004000, 24'h808000, 2'b11);
        set_ops(2, 24'h004000, 24'h008000, 2'b11);
        set_ops(3, 24'h004000, 24'h004000, 2'b11);
        expect_txn(0, 24'h001000, 1'b0, 1'b1);
        expect_txn(1, 24'h802000, 1'b0, 1'b1);
        expect_txn(2, 24'h002000, 1'b0, 1'b1);
        expect_txn(3, 24'h004000, 1'b0, 1'b1);
        expect_txn(0, 24'h001000, 1'b0, 1'b1);
        bus.req = 4'b1111;
        wait_gnt(0);
        wait_gnt(1);
        wait_gnt(2);
        wait_gnt(3);
        wait_gnt(0);
        bus.req = 4'b0000;
        drain();

        // 3: au never completes -> timeout, then a normal op
        hang = 1'b1;
        expect_txn(0, 24'h000000, 1'b1, 1'b1);
        bus.req[0] = 1'b1;
        wait_gnt(0);
        bus.req[0] = 1'b0;
        drain();
        hang = 1'b0;
        expect_txn(1, 24'h802000, 1'b0, 1'b1);
        bus.req[1] = 1'b1;
        wait_gnt(1);
        bus.req[1] = 1'b0;
        drain();

        // 4: au_busy high for 5 cycles after gnt
        bus.au_busy = 1'b1;
        expect_txn(2, 24'h002000, 1'b0, 1'b1);
        bus.req[2] = 1'b1;
        wait_gnt(2);
        bus.req[2] = 1'b0;
        begin
            logic early;
            early = 1'b0;
            for (int n = 0; n < 5; n++) begin
                early |= bus.au_start;
                @(posedge clk);
                #1;
            end
            bus.au_busy = 1'b0;
            early |= bus.au_start;
            chk("au_start_held_off", 128'(early), 128'(0));
            @(posedge clk);
            #1;
            chk("au_start_after_busy", 128'(bus.au_start), 128'(1));
        end
        drain();

        // 5: reset in the middle of a divide, then pointer back at 0
        expect_txn(1, 24'h802000, 1'b0, 1'b0);
        bus.req[1] = 1'b1;
        wait_gnt(1);
        bus.req[1] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        do_reset();
        chk("abort_queue_empty", 128'(aq.size()), 128'(0));
        expect_txn(2, 24'h002000, 1'b0, 1'b1);
        expect_txn(3, 24'h004000, 1'b0, 1'b1);
        expect_txn(3, 24'h004000, 1'b0, 1'b1);
        bus.req[2] = 1'b1;
        bus.req[3] = 1'b1;
        wait_gnt(2);
        bus.req[2] = 1'b0;
        wait_gnt(3);

        // 6: req[0] raised and withdrawn while busy; req[3] stays up
        repeat (5) @(posedge clk);
        #1;
        bus.req[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.req[0] = 1'b0;
        wait_gnt(3);
        bus.req[3] = 1'b0;
        drain();
        repeat (5) @(posedge clk);
        chk("gnt_queue_empty", 128'(gq.size()), 128'(0));
        chk("rsp_queue_empty", 128'(rq.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/au_arbiter.md
Name: au_arbiter

Overview:
Round-robin arbiter and sequencer that shares one arithmetic unit (au: add/mul/div with 24-cycle reciprocal) between N requesters, e.g. the Kalman predict/update matrix engines. It accepts one request at a time, latches its operands, and drives the au start/operand handshake. It then waits for au done, or a timeout, and returns the S9.14 sign-magnitude result to the owning requester. Operand values pass through unmodified; no arithmetic is done here.

Parameters:
N, 4, number of requesters (2..8)
W, 24, datapath width (sign-magnitude S9.14)
TIMEOUT, 64, max cycles from au_start to au_done before error (>= 32)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
req  in  N  per-requester request, held high with operands stable until gnt
req_R  in  N*W  R operand per requester, slice i = [i*W +: W]
req_S  in  N*W  S operand per requester
req_imm  in  N*W  immediate per requester
req_op  in  N*2  op_sel per requester (2'b11 = DIV)
req_ysel  in  N*2  mul_y_sel per requester
gnt  out  N  one-hot acceptance pulse, 1 cycle
rsp_valid  out  N  one-hot response pulse, 1 cycle
rsp_data  out  W  result, valid while rsp_valid != 0
rsp_err  out  1  timeout flag, qualified by rsp_valid
busy  out  1  high whenever state != IDLE
au_start  out  1  start pulse to au
au_R, au_S, au_Iimm  out  W each  latched operands to au
au_op_sel, au_mul_y_sel  out  2 each  latched controls to au
au_result  in  W  au result
au_done  in  1  au completion (level, held until next start)
au_busy  in  1  au busy

Behaviour:
- Reset: state IDLE, gnt=0, rsp_valid=0, rsp_data=0, rsp_err=0, au_start=0, all au operand/control outputs=0, rr pointer=0 (requester 0 highest priority), timer=0. Reset mid-operation aborts silently: no response is issued, and the in-flight au result is discarded.
- All outputs are registered.
- IDLE: if any req bit is set, pick the first set bit scanning from ptr upward with wrap (ptr, ptr+1, ..., N-1, 0, ...). On that edge: latch that requester's operands into au_* regs, store owner index, assert gnt[owner] for one cycle, go ISSUE. If req=0, stay in IDLE.
- ISSUE: wait while au_busy=1. When au_busy=0: au_start=1 for exactly one cycle, timer cleared, go WAIT.
- WAIT: timer increments each cycle.
  - If au_done=1 and au_start was not asserted in the previous cycle (ignore stale done): rsp_data<=au_result, rsp_err<=0, go RESP.
  - Else if timer reaches TIMEOUT-1: rsp_data<=0, rsp_err<=1, go RESP.
  - If done and timeout occur in the same cycle, done wins.
- RESP: rsp_valid[owner]=1 for one cycle, ptr<=(owner+1) mod N, go IDLE.
- Throughput: one request in flight. Minimum req-to-rsp_valid latency is 4 cycles plus au latency (inv: about 24).
- Requester protocol: req may drop any time before gnt; such a withdrawal is not an error. Req lines sampled outside IDLE are ignored. If req is still high on return to IDLE, it counts as a new request.
- rsp_data and au_* outputs hold their values until next overwritten.

Test Plan:
1. Reset, then req[1] with R=0x004000 (1.0), S=0x008000 (2.0), op=11, ysel=10 → gnt=0010 one cycle later. Then au_start single pulse, then rsp_valid=0010 with rsp_data=0x002000 (0.5) and rsp_err=0.
2. req=1111 simultaneously and held after each response → grants in order 0,1,2,3,0. Exactly one rsp_valid per grant, each matching its owner's inverse (1/4 → 0x001000, 1/-2 → 0x802000).
3. au model never asserts done, TIMEOUT=64 → rsp_valid pulses 64 cycles after au_start with rsp_err=1 and rsp_data=0. The next request is served normally.
4. au_busy held high for 5 cycles after gnt → au_start is delayed until the cycle after au_busy falls, and the result is still correct.
5. rst asserted mid-WAIT of a DIV → all outputs return to 0 immediately. No rsp_valid is issued, and after release req[2] is granted ahead of req[3] (ptr=0).
6. req[0] withdrawn before grant while req[3] stays high → only requester 3 is granted and responded.
